// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - loop-detector conditioner: sync, debounce, arrival count, service request FSM
module sensor_conditioner #(
    parameter int DEB_CYCLES   = 16,
    parameter int MIN_CARS     = 1,
    parameter int STUCK_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       raw_sns,
    input  logic       ack,
    output logic       sns,
    output logic [7:0] car_count,
    output logic       fault
);
    localparam int             DCW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [7:0]     MIN_CNT   = 8'(MIN_CARS);
    localparam logic [23:0]    STUCK_LIM = 24'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_REQ   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    logic           sync1_q, sync1_d, sync2_q, sync2_d;
    logic           deb_q, deb_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [23:0]    scnt_q, scnt_d;
    logic [7:0]     car_count_q, car_count_d, cnt_inc;
    state_t         state_q, state_d;
    logic           sns_q, sns_d, fault_q, fault_d;
    logic           arrival;

    always_comb begin
        sync1_d = raw_sns;
        sync2_d = sync1_q;

        deb_d  = deb_q;
        dcnt_d = '0;
        if (sync2_q != deb_q) begin
            if (dcnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
        arrival = deb_d & ~deb_q;

        scnt_d = '0;
        if (deb_q) begin
            scnt_d = (scnt_q == 24'hFF_FFFF) ? scnt_q : scnt_q + 24'd1;
        end

        cnt_inc = (car_count_q == 8'hFF) ? car_count_q : car_count_q + 8'd1;

        state_d     = state_q;
        car_count_d = car_count_q;
        if (state_q == S_FAULT) begin
            // Arrivals are not counted while faulted; leave once the sensor releases.
            if (!deb_q) begin
                state_d     = S_IDLE;
                car_count_d = 8'd0;
            end else if (ack) begin
                car_count_d = 8'd0;
            end
        end else if (scnt_q >= STUCK_LIM) begin
            state_d = S_FAULT;
        end else if (state_q == S_REQ) begin
            if (ack) begin
                // An arrival on the grant edge starts a fresh count of one.
                car_count_d = arrival ? 8'd1 : 8'd0;
                if (!arrival) begin
                    state_d = S_IDLE;
                end else if (8'd1 >= MIN_CNT) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_COUNT;
                end
            end else if (arrival) begin
                car_count_d = cnt_inc;
            end
        end else begin
            if (arrival) begin
                car_count_d = cnt_inc;
            end
            if (car_count_q >= MIN_CNT) begin
                state_d = S_REQ;
            end else if (car_count_q != 8'd0) begin
                state_d = S_COUNT;
            end else begin
                state_d = S_IDLE;
            end
        end

        sns_d   = (state_d == S_REQ) || (state_d == S_FAULT);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            dcnt_q      <= '0;
            scnt_q      <= '0;
            car_count_q <= 8'd0;
            state_q     <= S_IDLE;
            sns_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            dcnt_q      <= dcnt_d;
            scnt_q      <= scnt_d;
            car_count_q <= car_count_d;
            state_q     <= state_d;
            sns_q       <= sns_d;
            fault_q     <= fault_d;
        end
    end

    assign sns       = sns_q;
    assign fault     = fault_q;
    assign car_count = car_count_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - scoreboard bench for sensor_conditioner (MIN_CARS=1 and MIN_CARS=3 instances)
module tb_sensor_conditioner;
    typedef struct packed {
        logic [7:0] cnt;
        logic       sns;
        logic       flt;
    } obs_t;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       raw_a = 1'b0, ack_a = 1'b0, raw_b = 1'b0, ack_b = 1'b0;
    logic       sns_a, fault_a, sns_b, fault_b;
    logic [7:0] car_count_a, car_count_b;

    obs_t  exp_q[$];
    obs_t  obs_q[$];
    string nm_q[$];
    obs_t  e, o;
    string n;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    sensor_conditioner #(.DEB_CYCLES(4), .MIN_CARS(1), .STUCK_CYCLES(50)) dut_a (
        .clk(clk), .res(res), .raw_sns(raw_a), .ack(ack_a),
        .sns(sns_a), .car_count(car_count_a), .fault(fault_a)
    );

    sensor_conditioner #(.DEB_CYCLES(4), .MIN_CARS(3), .STUCK_CYCLES(50)) dut_b (
        .clk(clk), .res(res), .raw_sns(raw_b), .ack(ack_b),
        .sns(sns_b), .car_count(car_count_b), .fault(fault_b)
    );

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Records the required value and the DUT's present value for later scoring.
    task automatic expect_now(input string name, input bit on_b, input logic [7:0] cnt,
                              input logic s, input logic f);
        exp_q.push_back(obs_t'({cnt, s, f}));
        if (on_b) obs_q.push_back(obs_t'({car_count_b, sns_b, fault_b}));
        else      obs_q.push_back(obs_t'({car_count_a, sns_a, fault_a}));
        nm_q.push_back(name);
    endtask

    task automatic arrive(input bit on_b, input int hold);
        if (on_b) raw_b = 1'b1; else raw_a = 1'b1;
        step(hold);
        if (on_b) raw_b = 1'b0; else raw_a = 1'b0;
        step(hold);
    endtask

    task automatic test_reset;
        #12;
        expect_now("reset_a", 1'b0, 8'd0, 1'b0, 1'b0);
        expect_now("reset_b", 1'b1, 8'd0, 1'b0, 1'b0);
        #5 res = 1'b1;
        step(2);
        expect_now("post_reset_a", 1'b0, 8'd0, 1'b0, 1'b0);
        expect_now("post_reset_b", 1'b1, 8'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_basic;
        raw_a = 1'b1;
        step(5);
        expect_now("basic_edge5", 1'b0, 8'd0, 1'b0, 1'b0);
        step(1);
        expect_now("basic_edge6", 1'b0, 8'd1, 1'b0, 1'b0);
        step(1);
        expect_now("basic_edge7", 1'b0, 8'd1, 1'b1, 1'b0);
        raw_a = 1'b0;
        ack_a = 1'b1;
        step(1);
        ack_a = 1'b0;
        expect_now("basic_ack", 1'b0, 8'd0, 1'b0, 1'b0);
        step(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_glitch;
        raw_a = 1'b1; step(3);
        raw_a = 1'b0; step(3);
        expect_now("glitch_after_pulse", 1'b0, 8'd0, 1'b0, 1'b0);
        raw_a = 1'b1; step(1);
        raw_a = 1'b0; step(10);
        expect_now("glitch_settled", 1'b0, 8'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_min_cars;
        arrive(1'b1, 8);
        expect_now("mc_first", 1'b1, 8'd1, 1'b0, 1'b0);
        ack_b = 1'b1; step(2); ack_b = 1'b0;
        expect_now("mc_ack_ignored", 1'b1, 8'd1, 1'b0, 1'b0);
        arrive(1'b1, 8);
        expect_now("mc_second", 1'b1, 8'd2, 1'b0, 1'b0);
        arrive(1'b1, 8);
        expect_now("mc_third", 1'b1, 8'd3, 1'b1, 1'b0);
        ack_b = 1'b1; step(1); ack_b = 1'b0;
        expect_now("mc_ack_clear", 1'b1, 8'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_ack_arrival;
        raw_a = 1'b1; step(8);
        expect_now("aa_req", 1'b0, 8'd1, 1'b1, 1'b0);
        raw_a = 1'b0; step(8);
        raw_a = 1'b1; step(5);
        ack_a = 1'b1; step(1); ack_a = 1'b0;
        expect_now("aa_same_edge", 1'b0, 8'd1, 1'b1, 1'b0);
        step(1);
        expect_now("aa_hold", 1'b0, 8'd1, 1'b1, 1'b0);
        ack_a = 1'b1; step(1); ack_a = 1'b0;
        expect_now("aa_clear", 1'b0, 8'd0, 1'b0, 1'b0);
        raw_a = 1'b0; step(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_stuck;
        int edges;
        edges = 0;
        raw_a = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            edges = k;
            if (fault_a) break;
        end
        // deb rises on edge 6 and has been high 50 clocks by edge 56.
        n_checks++;
        if (!fault_a || edges < 56 || edges > 57) begin
            n_fail++;
            $display("FAIL stuck_latency: fault=%b after %0d edges, want fault=1 at edge 56..57",
                     fault_a, edges);
        end
        expect_now("stuck_fault", 1'b0, 8'd1, 1'b1, 1'b1);
        ack_a = 1'b1; step(1); ack_a = 1'b0;
        expect_now("stuck_ack", 1'b0, 8'd0, 1'b1, 1'b1);
        raw_a = 1'b0;
        step(6);
        expect_now("stuck_deb_fall", 1'b0, 8'd0, 1'b1, 1'b1);
        step(1);
        expect_now("stuck_idle", 1'b0, 8'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 254; i++) arrive(1'b0, 8);
        expect_now("sat_254", 1'b0, 8'd254, 1'b1, 1'b0);
        arrive(1'b0, 8);
        expect_now("sat_255", 1'b0, 8'd255, 1'b1, 1'b0);
        for (int i = 0; i < 45; i++) arrive(1'b0, 8);
        expect_now("sat_300", 1'b0, 8'd255, 1'b1, 1'b0);
        #3 res = 1'b0;
        #2;
        expect_now("sat_async_reset", 1'b0, 8'd0, 1'b0, 1'b0);
        #2 res = 1'b1;
        step(2);
        expect_now("sat_after_reset", 1'b0, 8'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d sns=%b fault=%b, want cnt=%0d sns=%b fault=%b",
                         n, o.cnt, o.sns, o.flt, e.cnt, e.sns, e.flt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_min_cars();
        test_ack_arrival();
        test_stuck();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive clocks a synchronized sensor level must hold before it is accepted.
REQ-002 Parameter MIN_CARS, default 1: accumulated arrivals needed to raise a service request (range 1..255).
REQ-003 Parameter STUCK_CYCLES, default 1000000: continuous debounced-high clocks that declare the sensor stuck (below 2^24).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 res  input  1  reset, asynchronous, active-low.
REQ-006 raw_sns  input  1  raw loop-detector level for side B, asynchronous to clk.
REQ-007 ack  input  1  level from the downstream light controller; high when side B has been granted green.
REQ-008 sns  output  1  registered service request to the light controller.
REQ-009 car_count  output  8  registered count of arrivals not yet served.
REQ-010 fault  output  1  registered stuck-sensor flag.

Function
REQ-011 raw_sns SHALL pass through a two-flop synchronizer; only the second flop (sync2) is used downstream.
REQ-012 Debounce: register deb plus counter dcnt sized to hold DEB_CYCLES; on any edge where sync2 equals deb, dcnt clears.
REQ-013 On any edge where sync2 differs from deb, dcnt increments; on the DEB_CYCLES-th consecutive such edge, deb takes sync2 and dcnt clears.
REQ-014 An arrival is a deb transition 0->1; car_count SHALL increment on the same edge deb rises, saturating at 255 (no wrap).
REQ-015 FSM states: IDLE (car_count 0), COUNT (0 < car_count < MIN_CARS), REQ, FAULT; encoded in 2 bits.
REQ-016 IDLE/COUNT: next state is REQ when the updated car_count >= MIN_CARS, COUNT when non-zero, else IDLE; sns=0 in both.
REQ-017 REQ: sns=1; the request is held until ack=1 is sampled.
REQ-018 REQ with ack=1: car_count clears to 0 and the state returns to IDLE; an arrival on that same edge leaves car_count=1, and the state then goes to COUNT, or to REQ when MIN_CARS=1.
REQ-019 ack is ignored in IDLE and COUNT; car_count is never cleared outside REQ or FAULT.
REQ-020 Stuck counter scnt (24 bits, saturating) increments while deb=1 and clears when deb=0.
REQ-021 When scnt reaches STUCK_CYCLES, the state goes to FAULT from any state, with priority over REQ-016..018.
REQ-022 FAULT: fault=1 and sns=1 (fail-safe, side B keeps being served); ack still clears car_count; arrivals are not counted.
REQ-023 FAULT exits to IDLE on the edge after deb falls; car_count is then 0.
REQ-024 sns and fault SHALL be decoded from the registered state only, glitch-free, with no combinational path from raw_sns or ack.

Reset
REQ-025 res=0 SHALL immediately force: sync flops 0, deb 0, dcnt 0, scnt 0, car_count 0, state IDLE, sns 0, fault 0.
REQ-026 Reset asserted mid-request SHALL drop sns at once, with no pending count retained.
REQ-027 After res deasserts, a raw_sns already high is treated as a new arrival once debounced.

Verification
REQ-028 DEB_CYCLES=4, MIN_CARS=1: raw_sns 0->1 held -> car_count=1 at edge 6, sns=1 at edge 7 after the change.
REQ-029 DEB_CYCLES=4: a 3-cycle raw_sns pulse, then a 1-cycle glitch -> deb never rises, car_count=0, sns=0.
REQ-030 MIN_CARS=3: three clean arrivals -> state COUNT after the first two, sns=1 only after the third; ack=1 -> car_count=0, sns=0 on the next edge.
REQ-031 MIN_CARS=1: in REQ, ack=1 on the same edge a new arrival is debounced -> car_count=1 and sns stays 1.
REQ-032 STUCK_CYCLES=50: raw_sns held high -> fault=1 and sns=1 after deb has been high 50 clocks; raw_sns low -> fault=0, IDLE after DEB_CYCLES+3 clocks.
REQ-033 300 arrivals with no ack -> car_count saturates at 255; res pulse low during REQ -> sns=0, car_count=0 asynchronously.
